// File: rtl/wash_mode_controller.sv
// -----------------------------------------------------------------------------
// wash_mode_controller
//   Top-level mode FSM of the washing machine. Conditions the front-panel
//   inputs, walks the machine through its modes, selects the program word that
//   the run/countdown controller consumes, and drives the buzzer.
//
// Ports
//   clk         in   1  system clock
//   rst_n       in   1  asynchronous active-low reset
//   power_btn   in   1  raw power key level (asynchronous)
//   start_btn   in   1  raw start/pause key level (asynchronous)
//   prog_btn    in   1  raw program-select key level (asynchronous)
//   door_open   in   1  raw door switch level, 1 = open (asynchronous)
//   hadFinish   in   1  run countdown exhausted (from run controller)
//   initTime    in   3  power-on countdown, honoured only in beginST
//   finishTime  in   3  finish countdown, honoured only in finishST
//   state       out  3  mode code
//   data        out 26  selected program word
//   prog_sel    out  2  current program index 0..2
//   alarm       out  1  buzzer enable
// -----------------------------------------------------------------------------
module wash_mode_controller #(
  parameter logic [25:0] PROG0 = 26'h1AA4D52,
  parameter logic [25:0] PROG1 = 26'h0912489,
  parameter logic [25:0] PROG2 = 26'h0000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        power_btn,
  input  logic        start_btn,
  input  logic        prog_btn,
  input  logic        door_open,
  input  logic        hadFinish,
  input  logic [2:0]  initTime,
  input  logic [2:0]  finishTime,
  output logic [2:0]  state,
  output logic [25:0] data,
  output logic [1:0]  prog_sel,
  output logic        alarm
);

  typedef enum logic [2:0] {
    SHUTDOWN_ST = 3'd0,
    BEGIN_ST    = 3'd1,
    SET_ST      = 3'd2,
    RUN_ST      = 3'd3,
    ERROR_ST    = 3'd4,
    PAUSE_ST    = 3'd5,
    FINISH_ST   = 3'd6
  } state_e;

  // Bit order of the conditioned inputs: {door, prog, start, power}
  logic [3:0]  raw_s;
  logic [3:0]  sync1_q;
  logic [3:0]  sync2_q;
  logic [2:0]  prev_q;

  logic        pwr_p_s;
  logic        start_p_s;
  logic        prog_p_s;
  logic        door_s;

  state_e      state_q, state_d;
  logic [1:0]  prog_sel_q, prog_sel_d;
  logic [25:0] data_q, data_d;
  logic        alarm_q, alarm_d;

  assign raw_s = {door_open, prog_btn, start_btn, power_btn};

  // Two-flop synchronizers for all raw inputs plus a previous-value flop for buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'd0;
      sync2_q <= 4'd0;
      prev_q  <= 3'd0;
    end else begin
      sync1_q <= raw_s;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q[2:0];
    end
  end

  // Rising-edge pulses are combinational on the third flop so the FSM reacts
  // on the third clock edge after the raw press.
  assign pwr_p_s   = sync2_q[0] & ~prev_q[0];
  assign start_p_s = sync2_q[1] & ~prev_q[1];
  assign prog_p_s  = sync2_q[2] & ~prev_q[2];
  assign door_s    = sync2_q[3];

  // Next-state, program-select and output-register logic
  always_comb begin
    state_d    = state_q;
    prog_sel_d = prog_sel_q;

    if (pwr_p_s && (state_q != SHUTDOWN_ST)) begin
      // Power key overrides every other event
      state_d = SHUTDOWN_ST;
    end else begin
      case (state_q)
        SHUTDOWN_ST: begin
          if (pwr_p_s) state_d = BEGIN_ST;
          else         state_d = SHUTDOWN_ST;
        end
        BEGIN_ST: begin
          if (initTime == 3'd0) state_d = SET_ST;
          else                  state_d = BEGIN_ST;
        end
        SET_ST: begin
          // A start press in the same cycle as a program press wins; the
          // program index is left alone so the started program is the one shown.
          if (start_p_s) begin
            state_d = door_s ? ERROR_ST : RUN_ST;
          end else if (prog_p_s) begin
            prog_sel_d = (prog_sel_q >= 2'd2) ? 2'd0 : prog_sel_q + 2'd1;
          end else begin
            state_d = SET_ST;
          end
        end
        RUN_ST: begin
          if (door_s)         state_d = ERROR_ST;
          else if (hadFinish) state_d = FINISH_ST;
          else if (start_p_s) state_d = PAUSE_ST;
          else                state_d = RUN_ST;
        end
        PAUSE_ST: begin
          if (!door_s && start_p_s) state_d = RUN_ST;
          else                      state_d = PAUSE_ST;
        end
        ERROR_ST: begin
          if (!door_s && start_p_s) state_d = PAUSE_ST;
          else                      state_d = ERROR_ST;
        end
        FINISH_ST: begin
          if (finishTime == 3'd0) state_d = SHUTDOWN_ST;
          else                    state_d = FINISH_ST;
        end
        default: state_d = SHUTDOWN_ST;  // illegal code 7 recovers
      endcase
    end

    // Program word tracks the index only while selecting; frozen elsewhere so
    // the run controller reloads the same program after pause or error.
    if (state_q == SET_ST) begin
      case (prog_sel_q)
        2'd0:    data_d = PROG0;
        2'd1:    data_d = PROG1;
        default: data_d = PROG2;
      endcase
    end else begin
      data_d = data_q;
    end

    alarm_d = (state_q == ERROR_ST) || (state_q == FINISH_ST);
  end

  // State, program index, program word and alarm registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SHUTDOWN_ST;
      prog_sel_q <= 2'd0;
      data_q     <= PROG0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      prog_sel_q <= prog_sel_d;
      data_q     <= data_d;
      alarm_q    <= alarm_d;
    end
  end

  assign state    = state_q;
  assign prog_sel = prog_sel_q;
  assign data     = data_q;
  assign alarm    = alarm_q;

endmodule

// File: tb/tb_wash_mode_controller.sv
// -----------------------------------------------------------------------------
// tb_wash_mode_controller
//   Table-driven bench for wash_mode_controller: each record is one action
//   (button press or level change), a settle time and the expected outputs.
//   Expected values go into a scoreboard queue when the action is driven and
//   are popped and compared once the settle time has elapsed. A few
//   hand-written sequences cover press latency, simultaneous keys and
//   asynchronous reset.
// -----------------------------------------------------------------------------
module tb_wash_mode_controller;

  localparam logic [25:0] P0 = 26'h1AA4D52;
  localparam logic [25:0] P1 = 26'h0912489;
  localparam logic [25:0] P2 = 26'h0000000;

  // Action codes
  localparam int A_NONE  = 0;
  localparam int A_PWR   = 1;
  localparam int A_START = 2;
  localparam int A_PROG  = 3;
  localparam int A_DOOR  = 4;
  localparam int A_HADF  = 5;
  localparam int A_INIT  = 6;
  localparam int A_FIN   = 7;

  typedef struct {
    int          act;
    logic [2:0]  val;
    int          wait_cyc;
    logic [2:0]  st;
    logic [1:0]  ps;
    logic [25:0] dt;
    logic        al;
    string       name;
  } vec_t;

  typedef struct {
    logic [2:0]  st;
    logic [1:0]  ps;
    logic [25:0] dt;
    logic        al;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        power_btn, start_btn, prog_btn, door_open, hadFinish;
  logic [2:0]  initTime, finishTime;
  logic [2:0]  state;
  logic [25:0] data;
  logic [1:0]  prog_sel;
  logic        alarm;

  int n_checks = 0;
  int n_pass   = 0;

  vec_t vecs[$];
  exp_t sbq[$];

  wash_mode_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .power_btn  (power_btn),
    .start_btn  (start_btn),
    .prog_btn   (prog_btn),
    .door_open  (door_open),
    .hadFinish  (hadFinish),
    .initTime   (initTime),
    .finishTime (finishTime),
    .state      (state),
    .data       (data),
    .prog_sel   (prog_sel),
    .alarm      (alarm)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [25:0] got, input logic [25:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic push_exp(input logic [2:0] st, input logic [1:0] ps,
                          input logic [25:0] dt, input logic al, input string name);
    exp_t e;
    e.st = st; e.ps = ps; e.dt = dt; e.al = al; e.name = name;
    sbq.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 26'd1, 26'd0);
    end else begin
      e = sbq.pop_front();
      chk({e.name, ".state"},    {23'd0, state},    {23'd0, e.st});
      chk({e.name, ".prog_sel"}, {24'd0, prog_sel}, {24'd0, e.ps});
      chk({e.name, ".data"},     data,              e.dt);
      chk({e.name, ".alarm"},    {25'd0, alarm},    {25'd0, e.al});
    end
  endtask

  // A press holds the raw key for 4 clocks and then lets the sync chain drain
  task automatic press(input int which);
    case (which)
      A_PWR:   power_btn = 1'b1;
      A_START: start_btn = 1'b1;
      default: prog_btn  = 1'b1;
    endcase
    step(4);
    power_btn = 1'b0; start_btn = 1'b0; prog_btn = 1'b0;
    step(3);
  endtask

  task automatic drive(input int act, input logic [2:0] val);
    case (act)
      A_PWR, A_START, A_PROG: press(act);
      A_DOOR:  door_open  = val[0];
      A_HADF:  hadFinish  = val[0];
      A_INIT:  initTime   = val;
      A_FIN:   finishTime = val;
      default: ;
    endcase
  endtask

  function automatic void add(input int act, input logic [2:0] val, input int w,
                              input logic [2:0] st, input logic [1:0] ps,
                              input logic [25:0] dt, input logic al, input string name);
    vec_t v;
    v.act = act; v.val = val; v.wait_cyc = w;
    v.st = st; v.ps = ps; v.dt = dt; v.al = al; v.name = name;
    vecs.push_back(v);
  endfunction

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    add(A_INIT, 3'd4, 1, 3'd1, 2'd0, P0, 1'b0, "begin_init4");
    add(A_INIT, 3'd0, 1, 3'd2, 2'd0, P0, 1'b0, "begin_init0");
    add(A_INIT, 3'd5, 1, 3'd2, 2'd0, P0, 1'b0, "set_idle");
    add(A_PROG, 3'd0, 0, 3'd2, 2'd1, P1, 1'b0, "prog1");
    add(A_PROG, 3'd0, 0, 3'd2, 2'd2, P2, 1'b0, "prog2");
    add(A_PROG, 3'd0, 0, 3'd2, 2'd0, P0, 1'b0, "prog_wrap0");
    add(A_PROG, 3'd0, 0, 3'd2, 2'd1, P1, 1'b0, "prog1_again");
    add(A_START,3'd0, 0, 3'd3, 2'd1, P1, 1'b0, "start_run");
    add(A_START,3'd0, 0, 3'd5, 2'd1, P1, 1'b0, "run_pause");
    add(A_START,3'd0, 0, 3'd3, 2'd1, P1, 1'b0, "pause_run");
    add(A_DOOR, 3'd1, 2, 3'd3, 2'd1, P1, 1'b0, "door_sync_lat");
    add(A_HADF, 3'd1, 1, 3'd4, 2'd1, P1, 1'b0, "door_beats_finish");
    add(A_HADF, 3'd0, 1, 3'd4, 2'd1, P1, 1'b1, "error_alarm");
    add(A_DOOR, 3'd0, 4, 3'd4, 2'd1, P1, 1'b1, "error_door_closed_hold");
    add(A_START,3'd0, 0, 3'd5, 2'd1, P1, 1'b0, "error_to_pause");
    add(A_DOOR, 3'd1, 3, 3'd5, 2'd1, P1, 1'b0, "pause_door_open");
    add(A_START,3'd0, 0, 3'd5, 2'd1, P1, 1'b0, "pause_start_door_open");
    add(A_DOOR, 3'd0, 3, 3'd5, 2'd1, P1, 1'b0, "pause_door_closed");
    add(A_START,3'd0, 0, 3'd3, 2'd1, P1, 1'b0, "pause_resume");
    add(A_HADF, 3'd1, 1, 3'd6, 2'd1, P1, 1'b0, "run_finish");
    add(A_HADF, 3'd0, 1, 3'd6, 2'd1, P1, 1'b1, "finish_alarm");
    add(A_INIT, 3'd0, 2, 3'd6, 2'd1, P1, 1'b1, "finish_ignores_init0");
    add(A_INIT, 3'd5, 0, 3'd6, 2'd1, P1, 1'b1, "finish_init5");
    add(A_FIN,  3'd0, 1, 3'd0, 2'd1, P1, 1'b1, "finish_done");
    add(A_FIN,  3'd5, 1, 3'd0, 2'd1, P1, 1'b0, "shutdown_alarm_off");
    add(A_FIN,  3'd0, 2, 3'd0, 2'd1, P1, 1'b0, "shutdown_ignores_fin0");
    add(A_FIN,  3'd5, 0, 3'd0, 2'd1, P1, 1'b0, "shutdown_fin5");
    add(A_PWR,  3'd0, 0, 3'd1, 2'd1, P1, 1'b0, "repower");
    add(A_INIT, 3'd0, 1, 3'd2, 2'd1, P1, 1'b0, "reset_keeps_sel");
    add(A_INIT, 3'd5, 0, 3'd2, 2'd1, P1, 1'b0, "set_again");
    add(A_DOOR, 3'd1, 3, 3'd2, 2'd1, P1, 1'b0, "set_door_open");
    add(A_START,3'd0, 0, 3'd4, 2'd1, P1, 1'b1, "start_door_open_err");
    add(A_PWR,  3'd0, 0, 3'd0, 2'd1, P1, 1'b0, "pwr_from_error");
    add(A_PWR,  3'd0, 0, 3'd1, 2'd1, P1, 1'b0, "repower2");
    add(A_INIT, 3'd0, 1, 3'd2, 2'd1, P1, 1'b0, "set3");
    add(A_INIT, 3'd5, 0, 3'd2, 2'd1, P1, 1'b0, "set3_init5");
    add(A_DOOR, 3'd0, 3, 3'd2, 2'd1, P1, 1'b0, "set3_door_closed");
    add(A_START,3'd0, 0, 3'd3, 2'd1, P1, 1'b0, "run3");
    add(A_PWR,  3'd0, 0, 3'd0, 2'd1, P1, 1'b0, "pwr_from_run");
    add(A_PWR,  3'd0, 0, 3'd1, 2'd1, P1, 1'b0, "repower3");
    add(A_INIT, 3'd0, 1, 3'd2, 2'd1, P1, 1'b0, "set4");
    add(A_INIT, 3'd5, 0, 3'd2, 2'd1, P1, 1'b0, "set4_init5");

    // Reset
    rst_n = 1'b0;
    power_btn = 1'b0; start_btn = 1'b0; prog_btn = 1'b0;
    door_open = 1'b0; hadFinish = 1'b0;
    initTime = 3'd5; finishTime = 3'd5;
    step(3);
    rst_n = 1'b1;
    step(1);
    push_exp(3'd0, 2'd0, P0, 1'b0, "reset");
    pop_check();

    // Power press latency: pulse acts on the third edge after the raw press
    power_btn = 1'b1;
    step(2);
    chk("pwr_latency_early.state", {23'd0, state}, 26'd0);
    step(1);
    chk("pwr_latency.state", {23'd0, state}, 26'd1);
    step(1);
    power_btn = 1'b0;
    step(3);

    // Table-driven actions
    for (int i = 0; i < vecs.size(); i++) begin
      push_exp(vecs[i].st, vecs[i].ps, vecs[i].dt, vecs[i].al, vecs[i].name);
      drive(vecs[i].act, vecs[i].val);
      step(vecs[i].wait_cyc);
      pop_check();
    end

    // prog and start pressed together in setST: start wins, index unchanged
    push_exp(3'd3, 2'd1, P1, 1'b0, "prog_start_same");
    prog_btn = 1'b1; start_btn = 1'b1;
    step(4);
    prog_btn = 1'b0; start_btn = 1'b0;
    step(3);
    pop_check();

    // Asynchronous reset mid-run, checked before the next clock edge
    push_exp(3'd0, 2'd0, P0, 1'b0, "async_reset");
    rst_n = 1'b0;
    #2;
    pop_check();
    step(1);
    rst_n = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wash_mode_controller.md
Name: wash_mode_controller

Overview:
- Top-level mode FSM for the washing machine; the counterpart of the run/countdown controller.
- Produces the 3-bit `state` code and the 26-bit program `data` word that the run controller consumes.
- Consumes the run controller's `hadFinish`, `initTime` and `finishTime` to advance the machine.
- Also conditions the front-panel buttons and drives the alarm/LED outputs.

Parameters:
- PROG0, 26'h1AA4D52, standard program; fields [25:23]..[2:0] = 3,5,2,2,3,5,2,2.
- PROG1, 26'h0912489, quick program; fields = 1,2,1,1,1,2,1,1.
- PROG2, 26'h0000000, test program; all fields zero, finishes immediately.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- power_btn, input, 1, raw power key level, asynchronous to clk.
- start_btn, input, 1, raw start/pause key level, asynchronous.
- prog_btn, input, 1, raw program-select key level, asynchronous.
- door_open, input, 1, raw door switch level, asynchronous; 1 = open.
- hadFinish, input, 1, run countdown exhausted.
- initTime, input, 3, power-on countdown; reaches 0 in beginST.
- finishTime, input, 3, finish countdown; reaches 0 in finishST.
- state, output, 3, mode code.
- data, output, 26, selected program word.
- prog_sel, output, 2, current program index 0..2.
- alarm, output, 1, buzzer enable.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is asynchronous and active-low, on rst_n.
- Reset values:
  - state = shutDownST (0), prog_sel = 0, data = PROG0, alarm = 0.
  - All synchronizer and edge-detect flops = 0.
- State encoding: shutDownST=0, beginST=1, setST=2, runST=3, errorST=4, pauseST=5, finishST=6. Code 7 is illegal and goes to shutDownST on the next clk.
- Input conditioning:
  - Every raw input passes through a 2-flop synchronizer.
  - Buttons get a third flop; the rising edge (sync & ~prev) gives a 1-cycle pulse: pwr_p, start_p, prog_p.
  - door_s is the synchronized door level.
  - Latency from a raw edge to the pulse is 3 clk.
- Transitions, priority top-down, evaluated each clk:
  1. pwr_p in any state other than shutDownST -> shutDownST.
  2. shutDownST: pwr_p -> beginST.
  3. beginST: initTime == 0 -> setST.
  4. setST:
     - prog_p -> prog_sel increments, wrapping 2 -> 0.
     - start_p with door_s = 0 -> runST.
     - start_p with door_s = 1 -> errorST.
  5. runST: door_s = 1 -> errorST; else hadFinish -> finishST; else start_p -> pauseST.
  6. pauseST: door_s = 0 and start_p -> runST.
  7. errorST: door_s = 0 and start_p -> pauseST.
  8. finishST: finishTime == 0 -> shutDownST.
- Simultaneous events:
  - pwr_p wins over everything.
  - In runST, door_open wins over hadFinish, and hadFinish wins over start_p.
  - prog_p and start_p in the same cycle in setST: the start transition is taken and prog_sel does not change.
- data:
  - Registered. In setST, data = PROG[prog_sel], updated the cycle after a prog_sel change.
  - Frozen in every other state, so the run controller reloads the same program after pause or error.
  - prog_sel is not cleared by shutDownST; it is cleared only by reset.
- alarm:
  - Registered, = 1 while state is errorST or finishST, 0 otherwise.
  - Asserts 1 clk after the state is entered.
- The run controller holds initTime/finishTime at 5 outside beginST/finishST, so a 0 on those inputs is only honoured in the matching state. A 0 seen in any other state is ignored.
- Reset mid-run: state returns to 0 immediately and asynchronously; outputs take their reset values.

Test Plan:
- Reset, then pulse power_btn for 4 clk -> state = 1 three to four clk after the press; drive initTime 5..0 -> state = 2 one clk after initTime = 0.
- In setST, press prog_btn 3 times -> prog_sel sequence 1, 2, 0; data sequence 0x0912489, 0x0000000, 0x1AA4D52.
- In setST with door_open = 0, press start -> state = 3; press start again -> state = 5; press start again -> state = 3; data unchanged throughout.
- In runST, raise door_open and hadFinish in the same cycle -> state = 4, alarm = 1; lower the door with no start press -> state stays 4; press start -> state = 5.
- In runST, assert hadFinish -> state = 6, alarm = 1; drive finishTime = 0 -> state = 0, alarm = 0.
- In runST, press power_btn -> state = 0; drive rst_n low asynchronously mid-run -> state = 0 and data = 0x1AA4D52 with no clk edge.
